// File: rtl/pc_gen_ras_pkg.sv
// Shared fetch-stage definitions: default geometry, reset vector and the
// encoding of the next-address source selected each cycle.
package pc_gen_ras_pkg;

  localparam int              AW_DEF        = 32;
  localparam int              STEP_DEF      = 4;
  localparam logic [AW_DEF-1:0] RST_VEC_DEF = '0;
  localparam int              RAS_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    SEL_FLUSH,
    SEL_HOLD,
    SEL_RET,
    SEL_PRED,
    SEL_SEQ
  } next_sel_e;

endpackage

// File: rtl/pc_gen_ras_if.sv
// Fetch control bundle: redirect/prediction/call-return hints in,
// fetch address, link value and return-stack status out.
interface pc_gen_ras_if
  import pc_gen_ras_pkg::*;
#(
  parameter int AW = AW_DEF
);

  logic          Flush;
  logic [AW-1:0] FlushAddr;
  logic          RasClr;
  logic          Stall;
  logic          PredTaken;
  logic [AW-1:0] PredAddr;
  logic          IsCall;
  logic          IsRet;
  logic [AW-1:0] InstrAddr;
  logic [AW-1:0] PC;
  logic          RasEmpty;
  logic          RasFull;

  modport master (
    output Flush, FlushAddr, RasClr, Stall, PredTaken, PredAddr, IsCall, IsRet,
    input  InstrAddr, PC, RasEmpty, RasFull
  );

  modport slave (
    input  Flush, FlushAddr, RasClr, Stall, PredTaken, PredAddr, IsCall, IsRet,
    output InstrAddr, PC, RasEmpty, RasFull
  );

endinterface

// File: rtl/pc_gen_ras_ret_addr_stack.sv
// Circular return-address stack; a push when full overwrites the oldest
// entry, and push+pop together replaces the top entry in place.
module ret_addr_stack
  import pc_gen_ras_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [AW-1:0] data,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] entries_q [RAS_DEPTH];
  logic [AW-1:0] entries_d [RAS_DEPTH];
  logic [PW-1:0] top_idx;
  logic          do_pop;

  assign top_idx = ptr_q - PW'(1);
  assign top     = entries_q[top_idx];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(RAS_DEPTH));
  assign do_pop  = pop && !empty;

  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    entries_d = entries_q;
    if (clr) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push && do_pop) begin
      entries_d[top_idx] = data;
    end else if (push) begin
      entries_d[ptr_q] = data;
      ptr_d            = ptr_q + PW'(1);
      if (!full) begin
        count_d = count_q + CW'(1);
      end
    end else if (do_pop) begin
      ptr_d   = top_idx;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry contents are never reset; a zero count masks stale data.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch-PC generator: holds the fetch address and picks the next one from
// redirect, stall, return stack, predicted target or the sequential path.
module pc_gen_ras
  import pc_gen_ras_pkg::*;
#(
  parameter int          AW        = AW_DEF,
  parameter int          STEP      = STEP_DEF,
  parameter logic [AW-1:0] RST_VEC = AW'(RST_VEC_DEF),
  parameter int          RAS_DEPTH = RAS_DEPTH_DEF
) (
  input logic         Clk,
  input logic         Rst,
  pc_gen_ras_if.slave bus
);

  logic [AW-1:0] instr_addr_q, instr_addr_d;
  logic [AW-1:0] pc;
  logic [AW-1:0] ras_top;
  logic          ras_empty;
  logic          ras_full;
  logic          advance;
  next_sel_e     sel;

  assign pc      = instr_addr_q + AW'(STEP);
  assign advance = !bus.Flush && !bus.Stall;

  ret_addr_stack #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (Clk),
    .rst   (Rst),
    .push  (advance && bus.IsCall),
    .pop   (advance && bus.IsRet),
    .clr   (bus.Flush && bus.RasClr),
    .data  (pc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_comb begin
    sel = SEL_SEQ;
    if (bus.Flush)                    sel = SEL_FLUSH;
    else if (bus.Stall)               sel = SEL_HOLD;
    else if (bus.IsRet && !ras_empty) sel = SEL_RET;
    else if (bus.PredTaken)           sel = SEL_PRED;
  end

  always_comb begin
    instr_addr_d = pc;
    case (sel)
      SEL_FLUSH: instr_addr_d = bus.FlushAddr;
      SEL_HOLD:  instr_addr_d = instr_addr_q;
      SEL_RET:   instr_addr_d = ras_top;
      SEL_PRED:  instr_addr_d = bus.PredAddr;
      default:   instr_addr_d = pc;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      instr_addr_q <= RST_VEC;
    end else begin
      instr_addr_q <= instr_addr_d;
    end
  end

  assign bus.InstrAddr = instr_addr_q;
  assign bus.PC        = pc;
  assign bus.RasEmpty  = ras_empty;
  assign bus.RasFull   = ras_full;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: directed vector table, hand-built call/return
// sequences and randomized traffic against a queue-based reference model.
module tb_pc_gen_ras;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] RST_VEC = 32'h0;

  typedef struct {
    bit          rst;
    bit          flush;
    logic [31:0] flushAddr;
    bit          rasClr;
    bit          stall;
    bit          predTaken;
    logic [31:0] predAddr;
    bit          isCall;
    bit          isRet;
    logic [31:0] expAddr;
    bit          expEmpty;
  } vec_t;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  logic [31:0] mAddr;
  logic [31:0] mRas[$];

  pc_gen_ras_if bus ();

  pc_gen_ras dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mkVec(bit rst, bit flush, logic [31:0] flushAddr, bit rasClr,
                                 bit stall, bit predTaken, logic [31:0] predAddr,
                                 bit isCall, bit isRet, logic [31:0] expAddr, bit expEmpty);
    vec_t v;
    v.rst = rst; v.flush = flush; v.flushAddr = flushAddr; v.rasClr = rasClr;
    v.stall = stall; v.predTaken = predTaken; v.predAddr = predAddr;
    v.isCall = isCall; v.isRet = isRet; v.expAddr = expAddr; v.expEmpty = expEmpty;
    return v;
  endfunction

  // Reference: the stack is a queue of return addresses, newest at the back.
  task automatic modelStep(input vec_t v);
    logic [31:0] link;
    logic [31:0] nxt;
    if (v.rst) begin
      mAddr = RST_VEC;
      mRas.delete();
    end else if (v.flush) begin
      mAddr = v.flushAddr;
      if (v.rasClr) mRas.delete();
    end else if (!v.stall) begin
      link = mAddr + 32'd4;
      if (v.isRet && mRas.size() > 0) begin
        nxt = mRas[$];
        if (v.isCall) mRas[$] = link;
        else void'(mRas.pop_back());
      end else begin
        if (v.isCall) begin
          if (mRas.size() == DEPTH) void'(mRas.pop_front());
          mRas.push_back(link);
        end
        nxt = v.predTaken ? v.predAddr : link;
      end
      mAddr = nxt;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    Rst           = v.rst;
    bus.Flush     = v.flush;
    bus.FlushAddr = v.flushAddr;
    bus.RasClr    = v.rasClr;
    bus.Stall     = v.stall;
    bus.PredTaken = v.predTaken;
    bus.PredAddr  = v.predAddr;
    bus.IsCall    = v.isCall;
    bus.IsRet     = v.isRet;
    @(posedge Clk);
    modelStep(v);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name);
    checkValue({name, "_addr"},  bus.InstrAddr, mAddr);
    checkValue({name, "_pc"},    bus.PC, mAddr + 32'd4);
    checkValue({name, "_empty"}, {31'b0, bus.RasEmpty}, {31'b0, mRas.size() == 0});
    checkValue({name, "_full"},  {31'b0, bus.RasFull}, {31'b0, mRas.size() == DEPTH});
  endtask

  task automatic step(input string name, input bit flush, input logic [31:0] flushAddr,
                      input bit rasClr, input bit predTaken, input logic [31:0] predAddr,
                      input bit isCall, input bit isRet);
    applyStimulus(mkVec(0, flush, flushAddr, rasClr, 0, predTaken, predAddr, isCall, isRet, 0, 0));
    checkOutput(name);
  endtask

  vec_t        tbl[13];
  logic [31:0] retAddr[9];
  logic [31:0] cur;
  logic [31:0] exp;
  vec_t        r;

  initial begin
    checks = 0;
    errors = 0;
    mAddr  = RST_VEC;
    Rst = 1'b1;
    bus.Flush = 0; bus.FlushAddr = 0; bus.RasClr = 0; bus.Stall = 0;
    bus.PredTaken = 0; bus.PredAddr = 0; bus.IsCall = 0; bus.IsRet = 0;

    //            rst fl  faddr     clr st pt paddr     call ret expAddr   empty
    tbl[0]  = mkVec(1, 0, 32'h0,    0, 0, 0, 32'h0,   0, 0, 32'h0,   1);
    tbl[1]  = mkVec(1, 0, 32'h0,    0, 0, 0, 32'h0,   0, 0, 32'h0,   1);
    tbl[2]  = mkVec(0, 0, 32'h0,    0, 0, 0, 32'h0,   0, 0, 32'h4,   1);
    tbl[3]  = mkVec(0, 0, 32'h0,    0, 0, 0, 32'h0,   0, 0, 32'h8,   1);
    tbl[4]  = mkVec(0, 0, 32'h0,    0, 0, 0, 32'h0,   0, 0, 32'hC,   1);
    tbl[5]  = mkVec(0, 1, 32'h100,  0, 0, 0, 32'h0,   0, 0, 32'h100, 1);
    tbl[6]  = mkVec(0, 0, 32'h0,    0, 1, 1, 32'h200, 0, 0, 32'h100, 1);
    tbl[7]  = mkVec(0, 0, 32'h0,    0, 0, 1, 32'h200, 0, 0, 32'h200, 1);
    tbl[8]  = mkVec(0, 1, 32'h40,   0, 0, 0, 32'h0,   0, 0, 32'h40,  1);
    tbl[9]  = mkVec(0, 0, 32'h0,    0, 0, 1, 32'h80,  1, 0, 32'h80,  0);
    tbl[10] = mkVec(0, 0, 32'h0,    0, 0, 0, 32'h0,   0, 0, 32'h84,  0);
    tbl[11] = mkVec(0, 0, 32'h0,    0, 0, 0, 32'h0,   0, 0, 32'h88,  0);
    tbl[12] = mkVec(0, 0, 32'h0,    0, 0, 0, 32'h0,   0, 1, 32'h44,  1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i]);
      checkValue($sformatf("tbl%0d_addr", i), bus.InstrAddr, tbl[i].expAddr);
      checkValue($sformatf("tbl%0d_pc", i), bus.PC, tbl[i].expAddr + 32'd4);
      checkValue($sformatf("tbl%0d_empty", i), {31'b0, bus.RasEmpty}, {31'b0, tbl[i].expEmpty});
      checkValue($sformatf("tbl%0d_full", i), {31'b0, bus.RasFull}, 32'd0);
    end

    // Nine nested calls overflow an 8-deep stack; the oldest return is lost.
    step("ovf_init", 1, 32'h1000, 1, 0, 0, 0, 0);
    cur = 32'h1000;
    for (int i = 0; i < 9; i++) begin
      retAddr[i] = cur + 32'd4;
      cur = 32'h2000 + 32'h100 * i;
      step($sformatf("call%0d", i), 0, 0, 0, 1, cur, 1, 0);
      checkValue($sformatf("call%0d_addr", i), bus.InstrAddr, cur);
      checkValue($sformatf("call%0d_full", i), {31'b0, bus.RasFull}, {31'b0, i >= 7});
    end
    for (int j = 0; j < 9; j++) begin
      exp = (j < 8) ? retAddr[8 - j] : cur + 32'd4;
      step($sformatf("ret%0d", j), 0, 0, 0, 0, 0, 0, 1);
      checkValue($sformatf("ret%0d_target", j), bus.InstrAddr, exp);
      cur = exp;
    end
    checkValue("ovf_empty", {31'b0, bus.RasEmpty}, 32'd1);

    // Flush with a pending return leaves the stack alone unless RasClr is set.
    step("fl_init", 1, 32'h500, 1, 0, 0, 0, 0);
    step("fl_call", 0, 0, 0, 1, 32'h600, 1, 0);
    step("fl_ret", 1, 32'h300, 0, 0, 0, 0, 1);
    checkValue("fl_redirect", bus.InstrAddr, 32'h300);
    checkValue("fl_kept", {31'b0, bus.RasEmpty}, 32'd0);
    step("fl_pop", 0, 0, 0, 0, 0, 0, 1);
    checkValue("fl_pop_target", bus.InstrAddr, 32'h504);
    step("fl_call2", 0, 0, 0, 1, 32'h700, 1, 0);
    step("fl_clr", 1, 32'h300, 1, 0, 0, 0, 0);
    checkValue("fl_clr_empty", {31'b0, bus.RasEmpty}, 32'd1);

    // Call and return together swap the top entry for the new link.
    step("cr_init", 1, 32'hFFC, 1, 0, 0, 0, 0);
    step("cr_call", 0, 0, 0, 1, 32'h50, 1, 0);
    step("cr_both", 0, 0, 0, 0, 0, 1, 1);
    checkValue("cr_target", bus.InstrAddr, 32'h1000);
    step("cr_ret", 0, 0, 0, 0, 0, 0, 1);
    checkValue("cr_newtop", bus.InstrAddr, 32'h54);
    checkValue("cr_empty", {31'b0, bus.RasEmpty}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      r = mkVec(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                $urandom & 32'hFFFF_FFFC, $urandom_range(1),
                ($urandom_range(7) == 0), ($urandom_range(3) == 0),
                $urandom & 32'hFFFF_FFFC, ($urandom_range(3) == 0),
                ($urandom_range(4) == 0), 0, 0);
      applyStimulus(r);
      checkOutput($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
